// File: rtl/pcie_datalink_pkg.sv
// Shared data-link definitions: ordered-set symbol codes, TS type and
// ordered-set receive parser states (used by pcie_ordered_set_rx and pcie_ltssm).
package pcie_datalink_pkg;

  // 8b/10b symbol codes used by training ordered sets
  localparam logic [7:0] COM    = 8'hBC;  // K28.5
  localparam logic [7:0] IDL    = 8'h7C;  // K28.3
  localparam logic [7:0] TS1_ID = 8'h4A;  // D10.2
  localparam logic [7:0] TS2_ID = 8'h45;  // D5.2

  // Training set flavour, encoded as it appears on ts_type_o
  typedef enum logic {
    TS1 = 1'b0,
    TS2 = 1'b1
  } os_type_e;

  // Ordered-set parser position: hunting for COM, or expecting beat 1/2/3
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_B1   = 2'd1,
    ST_B2   = 2'd2,
    ST_B3   = 2'd3
  } os_rx_state_e;

  // Identifier symbol that fills the tail of a TS of the given type
  function automatic logic [7:0] ts_id_symbol(input os_type_e t);
    return (t == TS2) ? TS2_ID : TS1_ID;
  endfunction

endpackage

// File: rtl/pcie_ordered_set_rx.sv
// Receive-side TS1/TS2/EIOS ordered-set parser feeding the LTSSM.
// Consumes a symbol-aligned 4-symbol-per-beat stream, decodes TS fields,
// counts consecutive identical TS sets and emits single-cycle event pulses.
module pcie_ordered_set_rx
  import pcie_datalink_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int CONSEC_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata_i,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep_i,
  input  logic                    s_axis_tvalid_i,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tuser_i,
  output logic                    s_axis_tready_o,
  output logic                    ts_valid_o,
  output logic                    ts_type_o,
  output logic [7:0]              link_num_o,
  output logic [7:0]              lane_num_o,
  output logic [7:0]              n_fts_o,
  output logic [7:0]              rate_id_o,
  output logic [7:0]              train_ctrl_o,
  output logic [CONSEC_WIDTH-1:0] ts_consec_o,
  output logic                    eios_o,
  output logic                    os_error_o
);

  // The beat layout below assumes exactly four symbols per beat.
  if (DATA_WIDTH != 32) begin : g_width_check
    $error("pcie_ordered_set_rx supports DATA_WIDTH = 32 only");
  end

  // Split the beat into symbols; sym[0] is the earliest on the wire.
  logic [7:0] sym [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_sym
    assign sym[gi] = s_axis_tdata_i[8*gi +: 8];
  end

  // Parser state and working capture of the set in progress
  os_rx_state_e state_q, state_d;
  logic [7:0]   link_cap_q, link_cap_d;
  logic [7:0]   lane_cap_q, lane_cap_d;
  logic [7:0]   nfts_cap_q, nfts_cap_d;
  logic [7:0]   rate_cap_q, rate_cap_d;
  logic [7:0]   ctrl_cap_q, ctrl_cap_d;
  os_type_e     type_cap_q, type_cap_d;

  // Registered outputs
  logic                    ts_valid_q, ts_valid_d;
  logic                    ts_type_q, ts_type_d;
  logic [7:0]              link_q, link_d;
  logic [7:0]              lane_q, lane_d;
  logic [7:0]              nfts_q, nfts_d;
  logic [7:0]              rate_q, rate_d;
  logic [7:0]              ctrl_q, ctrl_d;
  logic [CONSEC_WIDTH-1:0] consec_q, consec_d;
  logic                    eios_q, eios_d;
  logic                    os_error_q, os_error_d;

  // Beat classification
  logic       keep_ok;
  logic       com_beat;
  logic       eios_beat;
  logic       b1_ok;
  logic       body_ok;
  logic       set_match;
  logic [7:0] id_sym;
  logic       abort;
  logic       start_set;

  assign keep_ok   = (s_axis_tkeep_i == '1);
  // First beat of a TS: COM as K in byte 0, link/lane/N_FTS as data
  assign com_beat  = keep_ok && (sym[0] == COM) &&
                     (s_axis_tuser_i == KEEP_WIDTH'(1));
  assign eios_beat = keep_ok && (s_axis_tuser_i == '1) && (sym[0] == COM) &&
                     (sym[1] == IDL) && (sym[2] == IDL) && (sym[3] == IDL);
  // Second beat: rate/ctrl, then the first two identifier symbols
  assign b1_ok     = keep_ok && (s_axis_tuser_i == '0) && (sym[2] == sym[3]) &&
                     ((sym[2] == TS1_ID) || (sym[2] == TS2_ID));
  assign id_sym    = ts_id_symbol(type_cap_q);
  // Third and fourth beats: nothing but the latched identifier, all data
  assign body_ok   = keep_ok && (s_axis_tuser_i == '0) &&
                     (sym[0] == id_sym) && (sym[1] == id_sym) &&
                     (sym[2] == id_sym) && (sym[3] == id_sym);
  // Completed set compared against the last one presented on the outputs
  assign set_match = ({type_cap_q, link_cap_q, lane_cap_q, nfts_cap_q, rate_cap_q, ctrl_cap_q} ==
                      {ts_type_q, link_q, lane_q, nfts_q, rate_q, ctrl_q});

  // Next-state logic: walk the set beat by beat, abort on any malformed beat
  always_comb begin
    state_d    = state_q;
    link_cap_d = link_cap_q;
    lane_cap_d = lane_cap_q;
    nfts_cap_d = nfts_cap_q;
    rate_cap_d = rate_cap_q;
    ctrl_cap_d = ctrl_cap_q;
    type_cap_d = type_cap_q;
    ts_valid_d = 1'b0;
    eios_d     = 1'b0;
    os_error_d = 1'b0;
    ts_type_d  = ts_type_q;
    link_d     = link_q;
    lane_d     = lane_q;
    nfts_d     = nfts_q;
    rate_d     = rate_q;
    ctrl_d     = ctrl_q;
    consec_d   = consec_q;
    abort      = 1'b0;
    start_set  = 1'b0;

    if (s_axis_tvalid_i) begin
      unique case (state_q)
        ST_HUNT: begin
          if (eios_beat) begin
            eios_d   = 1'b1;
            consec_d = '0;
          end else if (com_beat) begin
            start_set = 1'b1;
          end
        end
        ST_B1: begin
          if (b1_ok) begin
            rate_cap_d = sym[0];
            ctrl_cap_d = sym[1];
            type_cap_d = (sym[2] == TS2_ID) ? TS2 : TS1;
            state_d    = ST_B2;
          end else begin
            abort = 1'b1;
          end
        end
        ST_B2: begin
          if (body_ok) state_d = ST_B3;
          else         abort   = 1'b1;
        end
        ST_B3: begin
          if (body_ok) begin
            state_d    = ST_HUNT;
            ts_valid_d = 1'b1;
            ts_type_d  = type_cap_q;
            link_d     = link_cap_q;
            lane_d     = lane_cap_q;
            nfts_d     = nfts_cap_q;
            rate_d     = rate_cap_q;
            ctrl_d     = ctrl_cap_q;
            if (!set_match)            consec_d = CONSEC_WIDTH'(1);
            else if (consec_q != '1)   consec_d = consec_q + CONSEC_WIDTH'(1);
          end else begin
            abort = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase

      // A malformed set is dropped; a COM beat that caused it starts a new one
      if (abort) begin
        os_error_d = 1'b1;
        consec_d   = '0;
        state_d    = ST_HUNT;
        start_set  = com_beat;
      end

      if (start_set) begin
        link_cap_d = sym[1];
        lane_cap_d = sym[2];
        nfts_cap_d = sym[3];
        state_d    = ST_B1;
      end
    end
  end

  // State, capture and output registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_HUNT;
      link_cap_q <= '0;
      lane_cap_q <= '0;
      nfts_cap_q <= '0;
      rate_cap_q <= '0;
      ctrl_cap_q <= '0;
      type_cap_q <= TS1;
      ts_valid_q <= 1'b0;
      ts_type_q  <= 1'b0;
      link_q     <= '0;
      lane_q     <= '0;
      nfts_q     <= '0;
      rate_q     <= '0;
      ctrl_q     <= '0;
      consec_q   <= '0;
      eios_q     <= 1'b0;
      os_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      link_cap_q <= link_cap_d;
      lane_cap_q <= lane_cap_d;
      nfts_cap_q <= nfts_cap_d;
      rate_cap_q <= rate_cap_d;
      ctrl_cap_q <= ctrl_cap_d;
      type_cap_q <= type_cap_d;
      ts_valid_q <= ts_valid_d;
      ts_type_q  <= ts_type_d;
      link_q     <= link_d;
      lane_q     <= lane_d;
      nfts_q     <= nfts_d;
      rate_q     <= rate_d;
      ctrl_q     <= ctrl_d;
      consec_q   <= consec_d;
      eios_q     <= eios_d;
      os_error_q <= os_error_d;
    end
  end

  assign s_axis_tready_o = 1'b1;
  assign ts_valid_o      = ts_valid_q;
  assign ts_type_o       = ts_type_q;
  assign link_num_o      = link_q;
  assign lane_num_o      = lane_q;
  assign n_fts_o         = nfts_q;
  assign rate_id_o       = rate_q;
  assign train_ctrl_o    = ctrl_q;
  assign ts_consec_o     = consec_q;
  assign eios_o          = eios_q;
  assign os_error_o      = os_error_q;

endmodule

// File: tb/tb_pcie_ordered_set_rx.sv
// Self-checking bench for pcie_ordered_set_rx: directed cases followed by
// randomized ordered-set transactions checked against a transaction-level model.
module tb_pcie_ordered_set_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic [3:0]  tuser;
  logic        tready;
  logic        ts_valid;
  logic        ts_type;
  logic [7:0]  link_num, lane_num, n_fts, rate_id, train_ctrl;
  logic [3:0]  ts_consec;
  logic        eios;
  logic        os_error;

  int compared   = 0;
  int mismatched = 0;

  // Expected model: last completed set {type, link, lane, nfts, rate, ctrl} and count
  logic [40:0] exp_set;
  logic [3:0]  exp_consec;
  logic [40:0] pool [4];

  pcie_ordered_set_rx #(
    .DATA_WIDTH  (32),
    .KEEP_WIDTH  (4),
    .CONSEC_WIDTH(4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .s_axis_tdata_i (tdata),
    .s_axis_tkeep_i (tkeep),
    .s_axis_tvalid_i(tvalid),
    .s_axis_tuser_i (tuser),
    .s_axis_tready_o(tready),
    .ts_valid_o     (ts_valid),
    .ts_type_o      (ts_type),
    .link_num_o     (link_num),
    .lane_num_o     (lane_num),
    .n_fts_o        (n_fts),
    .rate_id_o      (rate_id),
    .train_ctrl_o   (train_ctrl),
    .ts_consec_o    (ts_consec),
    .eios_o         (eios),
    .os_error_o     (os_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic ev, input logic ee, input logic er);
    chk("ts_valid", 64'(ts_valid), 64'(ev));
    chk("eios", 64'(eios), 64'(ee));
    chk("os_error", 64'(os_error), 64'(er));
    chk("fields", 64'({ts_type, link_num, lane_num, n_fts, rate_id, train_ctrl}), 64'(exp_set));
    chk("consec", 64'(ts_consec), 64'(exp_consec));
    chk("tready", 64'(tready), 64'(1'b1));
  endtask

  // One cycle on the bus; outputs checked 1 time unit after the edge
  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic [3:0] u,
                      input logic v, input logic ev, input logic ee, input logic er);
    @(negedge clk);
    tdata  = d;
    tkeep  = k;
    tuser  = u;
    tvalid = v;
    @(posedge clk);
    #1;
    $display("beat v=%0b d=%08h k=%h u=%h -> valid=%0b eios=%0b err=%0b consec=%0d",
             v, d, k, u, ts_valid, eios, os_error, ts_consec);
    check_all(ev, ee, er);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) beat($urandom, 4'($urandom), 4'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Beat i of a TS of type t with fields f = {link, lane, nfts, rate, ctrl}
  function automatic logic [31:0] ts_beat(input int i, input logic t, input logic [39:0] f);
    logic [7:0] id;
    id = t ? 8'h45 : 8'h4A;
    case (i)
      0:       return {f[23:16], f[31:24], f[39:32], 8'hBC};
      1:       return {id, id, f[7:0], f[15:8]};
      default: return {id, id, id, id};
    endcase
  endfunction

  function automatic logic [3:0] ts_user(input int i);
    return (i == 0) ? 4'b0001 : 4'b0000;
  endfunction

  // Completed set: repeat of the previous set counts up (saturating), else restarts at 1
  task automatic model_complete(input logic t, input logic [39:0] f);
    if ({t, f} == exp_set) exp_consec = (exp_consec == 4'd15) ? 4'd15 : exp_consec + 4'd1;
    else                   exp_consec = 4'd1;
    exp_set = {t, f};
  endtask

  // gap_mode: 0 none, 1 random gaps, 2 forced gap before beat 2
  task automatic send_ts(input logic t, input logic [39:0] f, input int gap_mode, input bit first_err);
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && gap_mode == 1 && $urandom_range(0, 4) == 0) gap($urandom_range(1, 2));
      if (i == 2 && gap_mode == 2) gap(2);
      if (i == 0 && first_err) begin
        exp_consec = 4'd0;
        beat(ts_beat(0, t, f), 4'hF, ts_user(0), 1'b1, 1'b0, 1'b0, 1'b1);
      end else if (i == 3) begin
        model_complete(t, f);
        beat(ts_beat(3, t, f), 4'hF, ts_user(3), 1'b1, 1'b1, 1'b0, 1'b0);
      end else begin
        beat(ts_beat(i, t, f), 4'hF, ts_user(i), 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic send_partial(input logic t, input logic [39:0] f, input int n);
    for (int i = 0; i < n; i++) beat(ts_beat(i, t, f), 4'hF, ts_user(i), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Set whose beat c (1..3) is broken by method m: bad keep, stray K flag, wrong symbol
  task automatic send_bad(input logic t, input logic [39:0] f, input int c, input int m);
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  u;
    int          j;
    send_partial(t, f, c);
    d = ts_beat(c, t, f);
    k = 4'hF;
    u = ts_user(c);
    case (m)
      0: k = 4'($urandom_range(0, 14));
      1: u = 4'b0001 << $urandom_range(1, 3);
      default: begin
        j = (c == 1) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 3));
        d[8*j +: 8] = d[8*j +: 8] ^ 8'h01;
      end
    endcase
    exp_consec = 4'd0;
    beat(d, k, u, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [39:0] f;
    logic [31:0] d;
    logic [40:0] s;
    int          kind;

    exp_set    = '0;
    exp_consec = '0;
    tdata      = '0;
    tkeep      = '0;
    tuser      = '0;
    tvalid     = 1'b0;
    rst        = 1'b1;
    for (int i = 0; i < 4; i++) pool[i] = {$urandom, $urandom};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Basic TS1
    f = 40'h01_00_20_02_00;
    send_ts(1'b0, f, 0, 1'b0);
    chk("first_ts1_consec", 64'(ts_consec), 64'd1);

    // 20 identical TS2 back-to-back, then one with a mid-set gap
    f = 40'hA5_03_1F_06_04;
    for (int n = 0; n < 20; n++) send_ts(1'b1, f, 0, 1'b0);
    chk("saturated_consec", 64'(ts_consec), 64'd15);
    send_ts(1'b1, f, 2, 1'b0);
    chk("gap_consec", 64'(ts_consec), 64'd15);

    // TS1 with a TS2 identifier in beat 2 byte 1
    send_partial(1'b0, 40'h11_22_33_44_55, 2);
    d = ts_beat(2, 1'b0, 40'h11_22_33_44_55);
    d[15:8] = 8'h45;
    exp_consec = 4'd0;
    beat(d, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // EIOS after a good set clears the count
    send_ts(1'b0, f, 0, 1'b0);
    exp_consec = 4'd0;
    beat(32'h7C7C7CBC, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
    // Same bytes with only byte 0 as K: a TS start, not an EIOS
    beat(32'h7C7C7CBC, 4'hF, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_ts(1'b1, 40'h07_01_10_02_08, 0, 1'b1);

    // COM arriving while in the third beat position
    send_partial(1'b0, 40'h21_02_40_02_01, 2);
    send_ts(1'b1, 40'h31_03_50_04_02, 0, 1'b1);
    chk("com_abort_link", 64'(link_num), 64'h31);

    // Reset asserted mid-set
    send_partial(1'b0, 40'h41_04_60_02_00, 2);
    #2;
    rst    = 1'b1;
    tvalid = 1'b0;
    #1;
    exp_set    = '0;
    exp_consec = '0;
    check_all(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    send_ts(1'b0, 40'h01_00_20_02_00, 0, 1'b0);

    // Randomized transaction stream
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 6);
      s    = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) s = {$urandom, $urandom};
      case (kind)
        0, 1: send_ts(s[40], s[39:0], 1, 1'b0);
        2:    send_bad(s[40], s[39:0], $urandom_range(1, 3), $urandom_range(0, 2));
        3: begin
          exp_consec = 4'd0;
          beat(32'h7C7C7CBC, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        4: begin
          d = $urandom;
          if ($urandom_range(0, 1) == 0) begin
            if (d[7:0] == 8'hBC) d[7:0] = 8'h00;
            beat(d, 4'($urandom), 4'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
          end else begin
            d[7:0] = 8'hBC;
            beat(d, 4'($urandom_range(0, 14)), 4'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
          end
        end
        5: begin
          send_partial(s[40], s[39:0], $urandom_range(1, 3));
          s = pool[$urandom_range(0, 3)];
          send_ts(s[40], s[39:0], 1, 1'b1);
        end
        default: send_ts(exp_set[40], exp_set[39:0], 0, 1'b0);
      endcase
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pcie_ordered_set_rx.md
# pcie_ordered_set_rx

Receive-side training ordered-set parser that sits directly upstream of `pcie_ltssm`. It consumes the symbol-aligned PHY AXIS stream and recognises TS1, TS2 and EIOS ordered sets. It presents decoded TS fields, a count of consecutive identical TS sets, and single-cycle event pulses that the LTSSM uses for its Polling, Configuration and Recovery transitions.

## Interface
- `DATA_WIDTH`, 32: symbol beat width. Only 32 (4 symbols per beat) is supported; other values are an elaboration error.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: byte enables and per-symbol K flags.
- `CONSEC_WIDTH`, 4: width of the consecutive-TS counter.

Ports:
- `clk_i`  in  1  one clock for the whole block.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `s_axis_tdata_i`  in  32  symbols. Byte 0 is the earliest symbol.
- `s_axis_tkeep_i`  in  4  byte enables. Must be 4'hF for a usable beat.
- `s_axis_tvalid_i`  in  1  beat valid.
- `s_axis_tuser_i`  in  4  K-character flag, one bit per byte.
- `s_axis_tready_o`  out  1  constant 1. The block never backpressures.
- `ts_valid_o`  out  1  one-cycle pulse when a complete, well-formed TS1/TS2 is received.
- `ts_type_o`  out  1  0 = TS1, 1 = TS2.
- `link_num_o`, `lane_num_o`, `n_fts_o`, `rate_id_o`, `train_ctrl_o`  out  8 each  decoded TS symbols 1–5.
- `ts_consec_o`  out  `CONSEC_WIDTH`  consecutive identical TS count, saturating.
- `eios_o`  out  1  one-cycle pulse when an EIOS is received.
- `os_error_o`  out  1  one-cycle pulse when an ordered set is aborted because it is malformed.

## Operation
- Symbol constants:
  - COM = 8'hBC (K)
  - IDL = 8'h7C (K)
  - TS1_ID = 8'h4A (D)
  - TS2_ID = 8'h45 (D)
- A COM always arrives in byte 0; alignment is handled upstream.
- A beat is accepted when `s_axis_tvalid_i` = 1.
- Beats with `s_axis_tvalid_i` = 0 are gaps. Gaps hold all state and do not abort an ordered set.
- State machine:
  - ST_HUNT (reset state). Beat = COM, IDL, IDL, IDL with K flags 4'hF: pulse `eios_o` and stay in ST_HUNT. Byte 0 = COM (K) and bytes 1–3 are data: capture link, lane and N_FTS, then go to ST_B1. Any other beat: stay in ST_HUNT with no error.
  - ST_B1. Capture rate and training control from bytes 0–1. Bytes 2–3 must be equal and be either TS1_ID or TS2_ID, and the tentative type is latched from them. Go to ST_B2.
  - ST_B2, then ST_B3. All 4 bytes must equal the latched ID with K = 0. ST_B3 completes the set and returns to ST_HUNT.
- Abort: any check failure, `s_axis_tkeep_i` ≠ 4'hF, or any K flag set in ST_B1–ST_B3. On abort: pulse `os_error_o`, clear `ts_consec_o`, go to ST_HUNT.
  - Exception: if the aborting beat is itself a valid COM beat 0, it is re-parsed as a new set and the next state is ST_B1.
- On completion:
  - The captured fields are copied to the outputs. Outputs hold until the next completion.
  - If type and all five fields equal the previously completed set, `ts_consec_o` increments and saturates at all-ones. Otherwise it loads 1.
- EIOS clears `ts_consec_o` to 0.
- Fields are never updated from a partial or aborted set.

## Timing
- All outputs are registered.
- `ts_valid_o`, `eios_o` and `os_error_o` assert in the cycle after the qualifying beat is accepted, for exactly one cycle.
- Back-to-back TS sets with no gaps give one `ts_valid_o` every 4 cycles.
- Reset values: all outputs 0, except `s_axis_tready_o` = 1. State returns to ST_HUNT.
- Reset asserted mid-set discards the partial set with no pulses.
- Only one of the three pulses can be active in any cycle. In the COM-abort case, `os_error_o` pulses and the new set continues.

## Structure
- Symbol constants, an `os_type_e` enum (TS1, TS2) and the parser-state enum go in `pcie_datalink_pkg`, shared with `pcie_ltssm`.
  - The state enum must be sized to hold all its values; no truncated enum widths.
- Single module. No sub-module is needed.
  - Field capture and the previous-set compare are in-module registers.
  - The compare is a 41-bit equality: type plus 5×8 bits.

## Test plan
- TS1 with link 8'h01, lane 8'h00, N_FTS 8'h20, rate 8'h02, ctrl 8'h00, sent as 4 contiguous beats → `ts_valid_o` pulse one cycle after beat 3, `ts_type_o` = 0, fields match, `ts_consec_o` = 1.
- 20 identical TS2 back-to-back, then a tvalid gap inserted mid-set → `ts_consec_o` saturates at 15, one `ts_valid_o` per set, and the gap has no effect.
- TS1 whose beat 2 byte 1 is 8'h45 → `os_error_o` pulse, no `ts_valid_o`, `ts_consec_o` = 0, outputs keep the prior fields.
- Beat BC/7C/7C/7C with tuser 4'hF → `eios_o` pulse and `ts_consec_o` cleared. The same bytes with tuser 4'h1 produce no pulse.
- COM beat arriving in ST_B2 → `os_error_o` pulse, then the new set completes 3 beats later with its own fields.
- `rst_i` asserted during ST_B2 → all outputs 0 immediately, and the next full TS1 is parsed normally.
